pio_in_irq: RTL and testbench
=============================

# pio_in_irq

Avalon-MM slave input port: the companion to the output PIO, carrying external signals (sensor lines, IR beam break, encoder index, board switches) from the board back into the Nios II core. Samples a 32-bit `in_port` through a synchronizer and detects per-bit edges into a sticky capture register. Raises a level `irq` for edges on unmasked bits. Sits on the same Avalon bus and register footprint (4 word addresses) as the output PIO.

## Interface
- `WIDTH`, 32: number of active input bits. Bits `[31:WIDTH]` read as 0.
- `RESET_MASK`, 32'h0: reset value of the interrupt mask register.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  32  external inputs; asynchronous to `clk`.
- `readdata`  out  32  read data; combinational from `address`, zero wait states.
- `irq`  out  1  level interrupt to the CPU.

## Operation
- Register map:
  - 0 DATA (RO): synchronized `in_port`.
  - 1 MASK (RW): per-bit irq enable.
  - 2 EDGE (R / write-1-to-clear): sticky capture register.
  - 3 POL (RW): per-bit edge select. 0 = rising, 1 = falling.
- A write is `chipselect && !write_n`. Writes to address 0 are ignored.
- Reads have no side effects. Unused or out-of-width bits read 0.
- Pipeline: `in_port` -> `sync0` -> `sync1` (only with the macro) -> `smp`. `prev` holds the previous `smp`.
- Edge detection: `rise = smp & ~prev`, `fall = ~smp & prev`, `hit = POL ? fall : rise` (per bit).
- EDGE update each cycle: `EDGE <= (EDGE & ~clr) | (hit & armed)`, where `clr` = `writedata` when writing address 2, else 0.
  - A new edge wins over a simultaneous clear of the same bit.
- `irq = |(EDGE & MASK)`: combinational from registers, no extra latency.
- Warm-up:
  - After reset deassertion, the `armed` flag stays 0 until `smp` and `prev` both hold real samples. Levels present at reset therefore never register as edges.
  - A 2-bit counter counts pipeline depth + 1 cycles, then sets `armed`. `armed` stays 1 until the next reset.
- Reset values: sync stages, `smp`, `prev`, EDGE, POL = 0; MASK = `RESET_MASK`; counter = 0; `armed` = 0.
  - Outputs at reset: `readdata` follows the selected register (0 unless address 1 is selected and `RESET_MASK` is nonzero). `irq` = 0.
  - Asserting reset mid-operation clears all state immediately and restarts the warm-up.

## Timing
- Let `in_port` change before rising edge k.
- With the macro:
  - `smp` updates at k+1; DATA is readable from cycle k+1.
  - EDGE bit sets at k+2; `irq` asserts in the same cycle if the bit is masked in.
- Without the macro: both events occur one cycle earlier.
- Pulses narrower than one `clk` period may be missed; no stretching.
- MASK/POL writes take effect on the next edge.
  - Changing POL while the input is static creates no edge.
  - Unmasking a bit whose EDGE is already set asserts `irq` the cycle after the write.
- EDGE clear: `irq` deasserts the cycle after the write, unless another masked bit is set.
- Warm-up is 3 cycles with the macro, 2 without. No edge is captured earlier than that.

## Configuration
- `PIO_IN_SYNC2_EN`
  - Defined: two-flop synchronizer (`sync0`, `sync1`). Required for truly asynchronous board inputs.
  - Undefined: single sample stage; `sync1` is absent and `smp` is fed from `sync0`. Latency and warm-up drop by one cycle.
  - Register map and software behaviour are otherwise identical.

## Structure
- Shared package `pio_pkg`:
  - address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_MASK`=1, `PIO_ADDR_EDGE`=2, `PIO_ADDR_POL`=3;
  - a `PIO_DW`=32 constant for the bus width.
- One natural sub-module: `pio_edge_det`, containing the synchronizer, `prev` register, warm-up counter and `hit` generation, parameterized by `WIDTH`.
- The top level keeps the register file, EDGE logic, read mux and `irq`.

## Test plan
- Hold `in_port`=32'hFFFF_FFFF through reset and release, wait 10 cycles -> EDGE reads 0, `irq`=0, DATA reads 32'hFFFF_FFFF.
- MASK=1, POL=0, raise bit 0 before edge k -> EDGE=1 and `irq`=1 at k+2 (macro defined) or k+1 (undefined); lowering bit 0 leaves EDGE=1.
- POL=32'h0000_0010, MASK=0, pulse bit 4 high for 4 cycles -> EDGE=32'h10 only after the falling edge; `irq` stays 0; writing MASK=32'h10 -> `irq`=1 the next cycle.
- EDGE bits 0 and 1 set, write 32'h1 to address 2 -> EDGE=32'h2; with MASK=32'h1, `irq` drops the next cycle.
- Write 32'h1 to address 2 in the same cycle a new rising edge is detected on bit 0 -> EDGE bit 0 remains 1.
- With `WIDTH`=8, toggle `in_port`[15:8] -> DATA and EDGE bits [31:8] read 0. Assert `reset_n`=0 mid-stream -> all registers cleared immediately and `irq`=0.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg: constants shared by the PIO input block, its bus interface and
// its testbench.
//   PIO_DW          Avalon data bus width
//   PIO_ADDR_*      word addresses of the four registers
package pio_pkg;
  localparam int PIO_DW = 32;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd2;
  localparam logic [1:0] PIO_ADDR_POL  = 2'd3;

  typedef logic [PIO_DW-1:0] pio_word_t;
endpackage

// File: rtl/pio_in_irq_if.sv
// pio_in_irq_if: Avalon-MM slave bus of the PIO input block.
//   address     word address (2 bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational from address (zero wait states)
// master drives the request side; slave drives readdata.
interface pio_in_irq_if;
  import pio_pkg::*;

  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  pio_word_t  writedata;
  pio_word_t  readdata;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);
endinterface

// File: rtl/pio_edge_det.sv
// pio_edge_det: input synchronizer, previous-sample register, warm-up
// counter and per-bit edge qualification for the PIO input block.
//   clk, reset_n  clock, async active-low reset
//   in_i          raw external inputs (asynchronous to clk)
//   pol_i         per-bit edge select: 0 rising, 1 falling
//   smp_o         synchronized sample (what DATA reads)
//   hit_o         per-bit selected edge between prev and smp
//   armed_o       1 once smp and prev both hold real post-reset samples
// Build option PIO_IN_SYNC2_EN: two-flop synchronizer (sync0 -> sync1);
// undefined, smp comes straight from sync0 and warm-up is one cycle shorter.
module pio_edge_det #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] pol_i,
  output logic [WIDTH-1:0] smp_o,
  output logic [WIDTH-1:0] hit_o,
  output logic             armed_o
);
`ifdef PIO_IN_SYNC2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  logic [WIDTH-1:0] sync0_q, prev_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= '0;
      prev_q  <= '0;
    end else begin
      sync0_q <= in_i;
      prev_q  <= smp_o;
    end
  end

`ifdef PIO_IN_SYNC2_EN
  logic [WIDTH-1:0] sync1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync1_q <= '0;
    else          sync1_q <= sync0_q;
  end
  assign smp_o = sync1_q;
`else
  assign smp_o = sync0_q;
`endif

  // Count DEPTH+1 cycles after reset: by then prev holds a real sample too,
  // so levels present at reset never look like edges.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!armed_q) begin
      if (cnt_q == DEPTH) armed_d = 1'b1;
      else                cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign hit_o   = (pol_i & ~smp_o & prev_q) | (~pol_i & smp_o & ~prev_q);
  assign armed_o = armed_q;
endmodule

// File: rtl/pio_in_irq.sv
// pio_in_irq: Avalon-MM input PIO with sticky per-bit edge capture and a
// level interrupt.
//   clk, reset_n  clock, async active-low reset
//   avs           Avalon slave bus (pio_in_irq_if.slave)
//   in_port       external inputs, asynchronous to clk
//   irq           |(EDGE & MASK), combinational from registers
// Registers: 0 DATA (RO), 1 MASK (RW), 2 EDGE (R/W1C), 3 POL (RW).
// Bits [31:WIDTH] read as 0. Build option PIO_IN_SYNC2_EN selects a
// two-flop input synchronizer (see pio_edge_det).
module pio_in_irq
  import pio_pkg::*;
#(
  parameter int        WIDTH      = 32,
  parameter pio_word_t RESET_MASK = 32'h0
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_in_irq_if.slave        avs,
  input  logic [PIO_DW-1:0]  in_port,
  output logic               irq
);
  logic [WIDTH-1:0] mask_q, mask_d, pol_q, pol_d, edge_q, edge_d;
  logic [WIDTH-1:0] smp, hit, clr, wdat;
  logic             armed, wr;

  pio_edge_det #(.WIDTH(WIDTH)) u_edge_det (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (in_port[WIDTH-1:0]),
    .pol_i   (pol_q),
    .smp_o   (smp),
    .hit_o   (hit),
    .armed_o (armed)
  );

  assign wr   = avs.chipselect & ~avs.write_n;
  assign wdat = avs.writedata[WIDTH-1:0];

  // Clear is applied before the OR so a new edge wins over a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    pol_d  = pol_q;
    clr    = '0;
    if (wr) begin
      case (avs.address)
        PIO_ADDR_MASK: mask_d = wdat;
        PIO_ADDR_EDGE: clr    = wdat;
        PIO_ADDR_POL:  pol_d  = wdat;
        default: ;
      endcase
    end
    edge_d = (edge_q & ~clr) | (hit & {WIDTH{armed}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= RESET_MASK[WIDTH-1:0];
      pol_q  <= '0;
      edge_q <= '0;
    end else begin
      mask_q <= mask_d;
      pol_q  <= pol_d;
      edge_q <= edge_d;
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      PIO_ADDR_DATA: avs.readdata = PIO_DW'(smp);
      PIO_ADDR_MASK: avs.readdata = PIO_DW'(mask_q);
      PIO_ADDR_EDGE: avs.readdata = PIO_DW'(edge_q);
      PIO_ADDR_POL:  avs.readdata = PIO_DW'(pol_q);
      default: ;
    endcase
  end

  assign irq = |(edge_q & mask_q);
endmodule

// File: tb/tb_pio_in_irq.sv
// tb_pio_in_irq: two instances (WIDTH=32 / RESET_MASK=0 and WIDTH=8 /
// RESET_MASK=8'hA5) driven with identical bus traffic and inputs, checked
// each cycle against a sample-history reference model.
module tb_pio_in_irq;
  import pio_pkg::*;

`ifdef PIO_IN_SYNC2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_port = 32'h0;
  logic        irq32, irq8;
  int          n_chk = 0, n_bad = 0;

  pio_in_irq_if if32 ();
  pio_in_irq_if if8 ();

  pio_in_irq #(.WIDTH(32), .RESET_MASK(32'h0)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .avs(if32), .in_port(in_port), .irq(irq32));
  pio_in_irq #(.WIDTH(8), .RESET_MASK(32'h0000_00A5)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .avs(if8), .in_port(in_port), .irq(irq8));

  always #5 clk = ~clk;

  function automatic logic [31:0] wm(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction
  function automatic logic [31:0] rm(int d);
    return (d == 0) ? 32'h0 : 32'h0000_00A5;
  endfunction

  // Reference model: an edge is the selected transition between two
  // consecutive post-reset input samples, visible LAT cycles after sampling.
  logic [31:0] hist[$];
  int          n_edges = 0;
  logic [31:0] m_mask[2] = '{32'h0, 32'h0000_00A5};
  logic [31:0] m_pol[2]  = '{32'h0, 32'h0};
  logic [31:0] m_edge[2] = '{32'h0, 32'h0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      n_edges = 0;
      for (int d = 0; d < 2; d++) begin
        m_mask[d] = rm(d) & wm(d);
        m_pol[d]  = 32'h0;
        m_edge[d] = 32'h0;
      end
    end else begin
      logic        w;
      logic [31:0] cur, old, hit, clr;
      n_edges++;
      hist.push_back(in_port);
      w = if32.chipselect && !if32.write_n;
      for (int d = 0; d < 2; d++) begin
        hit = 32'h0;
        if (n_edges >= LAT + 2) begin
          cur = hist[n_edges-LAT-1];
          old = hist[n_edges-LAT-2];
          hit = (~m_pol[d] & cur & ~old) | (m_pol[d] & ~cur & old);
        end
        clr = (w && if32.address == 2'd2) ? if32.writedata : 32'h0;
        m_edge[d] = (m_edge[d] & ~clr) | (hit & wm(d));
        if (w && if32.address == 2'd1) m_mask[d] = if32.writedata & wm(d);
        if (w && if32.address == 2'd3) m_pol[d]  = if32.writedata & wm(d);
      end
    end
  end

  function automatic logic [31:0] m_read(int d, logic [1:0] a);
    case (a)
      2'd0:    return (n_edges >= LAT) ? (hist[n_edges-LAT] & wm(d)) : 32'h0;
      2'd1:    return m_mask[d];
      2'd2:    return m_edge[d];
      default: return m_pol[d];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus(input logic cs, input logic wn, input logic [1:0] a,
                     input logic [31:0] wd);
    if32.chipselect = cs; if32.write_n = wn; if32.address = a; if32.writedata = wd;
    if8.chipselect  = cs; if8.write_n  = wn; if8.address  = a; if8.writedata  = wd;
  endtask

  // Idles the bus and sweeps all four addresses inside the low clock phase.
  task automatic check_all();
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    chk("irq32", {31'h0, irq32}, {31'h0, |(m_edge[0] & m_mask[0])});
    chk("irq8",  {31'h0, irq8},  {31'h0, |(m_edge[1] & m_mask[1])});
    for (int a = 0; a < 4; a++) begin
      bus(1'b0, 1'b1, 2'(a), 32'h0);
      #1;
      chk($sformatf("rd32_a%0d", a), if32.readdata, m_read(0, 2'(a)));
      chk($sformatf("rd8_a%0d", a),  if8.readdata,  m_read(1, 2'(a)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    bus(1'b1, 1'b0, a, wd);
    tick();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus(1'b0, 1'b1, a, 32'h0);
    #1;
    d = if32.readdata;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ ($urandom & $urandom & $urandom);
      r = $urandom_range(0, 5);
      if (r == 0)      bus(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else if (r == 1) bus(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      else if (r == 2) bus(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else             bus(1'b0, 1'b1, 2'd0, 32'h0);
      tick();
    end
  endtask

  logic [31:0] d;

  initial begin
    bus(1'b0, 1'b1, 2'd0, 32'h0);
    in_port = 32'hFFFF_FFFF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    rd(2'd0, d); chk("warm_data", d, 32'hFFFF_FFFF);
    rd(2'd2, d); chk("warm_edge", d, 32'h0);
    chk("warm_irq", {31'h0, irq32}, 32'h0);

    // rising edge on bit 0 with MASK=1: latency check
    wr(2'd1, 32'h1);
    wr(2'd3, 32'h0);
    in_port = 32'h0;
    repeat (LAT + 3) tick();
    in_port = 32'h1;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      chk("lat_irq", {31'h0, irq32}, {31'h0, i == LAT + 1});
    end
    in_port = 32'h0;
    repeat (LAT + 2) tick();
    rd(2'd2, d); chk("sticky_edge", d, 32'h1);

    // falling-edge polarity on bit 4, masked off, then unmask
    wr(2'd3, 32'h10);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'h10;
    repeat (4) tick();
    rd(2'd2, d); chk("pol_rise_ignored", d, 32'h0);
    in_port = 32'h0;
    repeat (LAT + 2) tick();
    rd(2'd2, d); chk("pol_fall_edge", d, 32'h10);
    chk("pol_masked_irq", {31'h0, irq32}, 32'h0);
    wr(2'd1, 32'h10);
    chk("unmask_irq", {31'h0, irq32}, 32'h1);

    // W1C of bit 0 while bit 1 stays set
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h1);
    in_port = 32'h3;
    repeat (LAT + 2) tick();
    rd(2'd2, d); chk("two_edges", d, 32'h3);
    wr(2'd2, 32'h1);
    rd(2'd2, d); chk("w1c_edge", d, 32'h2);
    chk("w1c_irq", {31'h0, irq32}, 32'h0);

    // clear coinciding with a new edge on the same bit
    in_port = 32'h2;
    repeat (LAT + 2) tick();
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'h3;
    repeat (LAT) tick();
    wr(2'd2, 32'h1);
    rd(2'd2, d); chk("edge_wins_clr", d & 32'h1, 32'h1);

    // upper-byte activity (WIDTH=8 instance ignores it) and random traffic
    for (int i = 0; i < 20; i++) begin
      in_port = in_port ^ 32'h0000_FF00;
      tick();
    end
    rand_cycles(1500);

    // asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    check_all();
    chk("rst_irq32", {31'h0, irq32}, 32'h0);
    chk("rst_irq8",  {31'h0, irq8},  32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    rand_cycles(1000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
